// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit beside ID: private EXE/MEM/WB destination tags,
// stall or forward-select generation, and a saturating stall counter.
module scoreboard_hazard_unit #(
  parameter int REG_AW     = 4,
  parameter int FORWARD_EN = 1,
  parameter int WB_HAZARD  = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              flush,
  input  logic              freeze,
  output logic              hazard_detected,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wb_en;
    logic              mem_r_en;
  } tag_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic WB_CHK = (WB_HAZARD != 0);
  localparam logic FWD    = (FORWARD_EN != 0);

  tag_t exe, mem, wb;
  tag_t nxt;

  logic a_exe, a_mem, a_wb;
  logic b_exe, b_mem, b_wb;
  logic raw, load_use;
  logic unused_tags;

  // Only the EXE copy of the load flag drives the load-use check
  assign unused_tags = ^{mem.mem_r_en, wb.mem_r_en};

  assign a_exe = exe.valid && exe.wb_en && (exe.dest == src1);
  assign a_mem = mem.valid && mem.wb_en && (mem.dest == src1);
  assign a_wb  = WB_CHK && wb.valid && wb.wb_en && (wb.dest == src1);

  assign b_exe = two_src && exe.valid && exe.wb_en && (exe.dest == src2);
  assign b_mem = two_src && mem.valid && mem.wb_en && (mem.dest == src2);
  assign b_wb  = two_src && WB_CHK && wb.valid && wb.wb_en
                 && (wb.dest == src2);

  assign raw = id_valid
               && (a_exe || a_mem || a_wb || b_exe || b_mem || b_wb);

  assign load_use = id_valid && exe.mem_r_en && (a_exe || b_exe);

  assign hazard_detected = FWD ? load_use : raw;

  always_comb begin
    fwd_sel_a = 2'd0;
    fwd_sel_b = 2'd0;
    if (FWD && id_valid && !hazard_detected) begin
      // Youngest producer wins
      if (a_exe)      fwd_sel_a = 2'd1;
      else if (a_mem) fwd_sel_a = 2'd2;
      else if (a_wb)  fwd_sel_a = 2'd3;
      if (b_exe)      fwd_sel_b = 2'd1;
      else if (b_mem) fwd_sel_b = 2'd2;
      else if (b_wb)  fwd_sel_b = 2'd3;
    end
  end

  always_comb begin
    nxt = '0;
    if (id_valid && !hazard_detected && !flush) begin
      nxt.valid    = 1'b1;
      nxt.dest     = id_dest;
      nxt.wb_en    = id_wb_en;
      nxt.mem_r_en = id_mem_r_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe          <= '0;
      mem          <= '0;
      wb           <= '0;
      stall_cycles <= '0;
    end else if (!freeze) begin
      wb  <= mem;
      mem <= exe;
      exe <= nxt;
      if (hazard_detected && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: four configurations share one stimulus,
// a vector table for forwarding mode plus directed multi-cycle sequences.
module tb_scoreboard_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [3:0] src1 = '0;
  logic [3:0] src2 = '0;
  logic two_src = 1'b0;
  logic [3:0] id_dest = '0;
  logic id_wb_en = 1'b0;
  logic id_mem_r_en = 1'b0;
  logic flush = 1'b0;
  logic freeze = 1'b0;

  logic f_hz, s_hz, w_hz, c_hz;
  logic [1:0] f_a, f_b, s_a, s_b, w_a, w_b, c_a, c_b;
  logic [15:0] f_cnt, s_cnt, w_cnt;
  logic [3:0] c_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  scoreboard_hazard_unit #(
    .REG_AW(4), .FORWARD_EN(1), .WB_HAZARD(0), .CNT_W(16)
  ) u_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
    .hazard_detected(f_hz), .fwd_sel_a(f_a), .fwd_sel_b(f_b),
    .stall_cycles(f_cnt)
  );

  scoreboard_hazard_unit #(
    .REG_AW(4), .FORWARD_EN(0), .WB_HAZARD(0), .CNT_W(16)
  ) u_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
    .hazard_detected(s_hz), .fwd_sel_a(s_a), .fwd_sel_b(s_b),
    .stall_cycles(s_cnt)
  );

  scoreboard_hazard_unit #(
    .REG_AW(4), .FORWARD_EN(0), .WB_HAZARD(1), .CNT_W(16)
  ) u_w (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
    .hazard_detected(w_hz), .fwd_sel_a(w_a), .fwd_sel_b(w_b),
    .stall_cycles(w_cnt)
  );

  scoreboard_hazard_unit #(
    .REG_AW(4), .FORWARD_EN(1), .WB_HAZARD(0), .CNT_W(4)
  ) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
    .hazard_detected(c_hz), .fwd_sel_a(c_a), .fwd_sel_b(c_b),
    .stall_cycles(c_cnt)
  );

  typedef struct {
    int v, s1, s2, two, d, wb, mr;
    int hz, a, b;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int s1, input int s2,
                       input int two, input int d, input int wb,
                       input int mr, input int fl, input int fr);
    id_valid    = 1'(v);
    src1        = 4'(s1);
    src2        = 4'(s2);
    two_src     = 1'(two);
    id_dest     = 4'(d);
    id_wb_en    = 1'(wb);
    id_mem_r_en = 1'(mr);
    flush       = 1'(fl);
    freeze      = 1'(fr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(int v, int s1, int s2, int two, int d,
                              int wb, int mr, int hz, int a, int b);
    vec_t t;
    t.v = v; t.s1 = s1; t.s2 = s2; t.two = two; t.d = d;
    t.wb = wb; t.mr = mr; t.hz = hz; t.a = a; t.b = b;
    return t;
  endfunction

  initial begin
    int ns, nw;

    // Forwarding-mode trace; expectations worked out cycle by cycle
    tbl[0]  = mk(1,  0,  0, 0,  3, 1, 1,  0, 0, 0);
    tbl[1]  = mk(1,  3,  5, 1,  4, 1, 0,  1, 0, 0);
    tbl[2]  = mk(1,  3,  5, 1,  4, 1, 0,  0, 2, 0);
    tbl[3]  = mk(1,  0,  0, 0,  2, 1, 0,  0, 0, 0);
    tbl[4]  = mk(1,  1,  2, 1,  6, 1, 0,  0, 0, 1);
    tbl[5]  = mk(1,  1,  2, 0,  7, 1, 0,  0, 0, 0);
    tbl[6]  = mk(1,  7,  6, 1,  8, 1, 0,  0, 1, 2);
    tbl[7]  = mk(1,  0,  0, 0,  8, 1, 0,  0, 0, 0);
    tbl[8]  = mk(1,  8,  7, 1,  1, 1, 0,  0, 1, 0);
    tbl[9]  = mk(0,  1,  0, 0,  0, 0, 0,  0, 0, 0);
    tbl[10] = mk(1,  9,  0, 0,  9, 1, 0,  0, 0, 0);
    tbl[11] = mk(1,  0,  0, 0, 10, 0, 0,  0, 0, 0);
    tbl[12] = mk(1, 10,  9, 1, 11, 1, 0,  0, 0, 2);
    tbl[13] = mk(1,  0,  0, 0, 12, 1, 1,  0, 0, 0);
    tbl[14] = mk(1, 11, 12, 1, 13, 1, 0,  1, 0, 0);
    tbl[15] = mk(1, 11, 12, 1, 13, 1, 0,  0, 0, 2);
    tbl[16] = mk(0,  0,  0, 0,  0, 0, 0,  0, 0, 0);

    do_reset();
    #2;
    chk("reset_hz", int'(f_hz), 0);
    chk("reset_fwd", int'({f_a, f_b}), 0);
    chk("reset_cnt", int'(f_cnt), 0);
    chk("reset_cnt_s", int'(s_cnt), 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].d,
            tbl[i].wb, tbl[i].mr, 0, 0);
      #2;
      chk($sformatf("vec%0d_hz", i), int'(f_hz), tbl[i].hz);
      chk($sformatf("vec%0d_a", i), int'(f_a), tbl[i].a);
      chk($sformatf("vec%0d_b", i), int'(f_b), tbl[i].b);
      tick();
    end
    chk("table_stall_cnt", int'(f_cnt), 2);

    // Stall-only mode: ADD R7 then MOV R8,R7
    do_reset();
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    ns = 0;
    nw = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 7, 0, 0, 8, 1, 0, 0, 0);
      #2;
      if (s_hz) ns++;
      if (w_hz) nw++;
      if (i == 0) chk("fwd_add_mov_a", int'(f_a), 1);
      if (i == 0) chk("stall_mode_fwd0", int'(s_a), 0);
      tick();
    end
    chk("stall_mode_hz_cycles", ns, 2);
    chk("wb_hazard_hz_cycles", nw, 3);
    chk("stall_mode_cnt", int'(s_cnt), 2);
    chk("wb_hazard_cnt", int'(w_cnt), 3);

    // Freeze with a load-use pending
    do_reset();
    drive(1, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 5, 1, 4, 1, 0, 0, 1);
      #2;
      chk($sformatf("freeze%0d_hz", i), int'(f_hz), 1);
      tick();
    end
    chk("freeze_cnt_held", int'(f_cnt), 0);
    drive(1, 3, 5, 1, 4, 1, 0, 0, 0);
    #2;
    chk("unfreeze_hz", int'(f_hz), 1);
    tick();
    #2;
    chk("unfreeze_next_hz", int'(f_hz), 0);
    chk("unfreeze_next_a", int'(f_a), 2);
    chk("unfreeze_cnt", int'(f_cnt), 1);

    // Flushed writer of R9 must not be seen by the next reader
    do_reset();
    drive(1, 0, 0, 0, 9, 1, 0, 1, 0);
    tick();
    drive(1, 9, 9, 1, 10, 1, 0, 0, 0);
    #2;
    chk("flush_hz_fwd", int'(f_hz), 0);
    chk("flush_fwd", int'({f_a, f_b}), 0);
    chk("flush_hz_stall", int'(s_hz), 0);
    tick();

    // Reset in the middle of a stall-only stall
    do_reset();
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    drive(1, 7, 0, 0, 8, 1, 0, 0, 0);
    tick();
    #2;
    chk("midstall_hz", int'(s_hz), 1);
    chk("midstall_cnt", int'(s_cnt), 1);
    rst = 1'b1;
    drive(1, 7, 0, 0, 8, 1, 0, 1, 1);
    tick();
    rst = 1'b0;
    drive(1, 7, 0, 0, 8, 1, 0, 0, 0);
    #2;
    chk("post_rst_hz", int'(s_hz), 0);
    chk("post_rst_cnt", int'(s_cnt), 0);

    // Twenty load-use stalls: 4-bit counter saturates
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 3, 1, 1, 0, 0);
      tick();
      drive(1, 3, 5, 1, 4, 1, 0, 0, 0);
      tick();
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("sat_cnt4", int'(c_cnt), 15);
    chk("sat_cnt16", int'(f_cnt), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the combinational hazard detector in the 5-stage ARM-style pipeline; sits beside the ID stage.
- Keeps its own EXE/MEM/WB destination tag pipeline, so the EXE and MEM stages no longer have to drive Dest/WB_en back to it.
- Selects stall-only or forwarding mode at elaboration (load-use stall only when forwarding is on), drives per-operand forward selects, and counts stall cycles.

Parameters:
- REG_AW, 4, register address width (2^REG_AW architectural registers).
- FORWARD_EN, 1, 1 = forwarding mode (stall only on load-use); 0 = stall on any RAW match.
- WB_HAZARD, 0, 1 = register file is not write-before-read, so the WB stage is also checked.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- src1  in  REG_AW  first source register.
- src2  in  REG_AW  second source register.
- two_src  in  1  src2 is actually read.
- id_dest  in  REG_AW  destination of the ID instruction.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_r_en  in  1  ID instruction is a load.
- flush  in  1  branch taken in EXE; squash the ID instruction.
- freeze  in  1  global pipeline hold (memory wait); all tags hold.
- hazard_detected  out  1  stall IF/ID and insert a bubble.
- fwd_sel_a  out  2  src1 forward select: 0 regfile, 1 EXE, 2 MEM, 3 WB.
- fwd_sel_b  out  2  src2 forward select, same encoding.
- stall_cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Tag stages EXE, MEM and WB each hold {valid, dest, wb_en, mem_r_en}.
- Reset (rst=1 at a clk edge): all stage valids 0 and stall_cycles 0. Reset wins over freeze and flush, including mid-stall. The cycle after reset: hazard_detected=0, fwd_sel_a/b=0.
- Stage update at a clk edge when rst=0:
  - freeze=1: all stages hold; flush is ignored.
  - freeze=0: WB<=MEM, MEM<=EXE.
  - EXE<=ID info with valid=1 when id_valid && !hazard_detected && !flush; otherwise EXE<=bubble (valid=0).
- Match definition: match_S(r) = S.valid && S.wb_en && S.dest==r.
  - src2 terms are evaluated only when two_src=1.
  - WB terms are evaluated only when WB_HAZARD=1.
- FORWARD_EN=0:
  - hazard_detected = id_valid && (any match on src1, or on src2 when enabled, in EXE, MEM or WB).
  - fwd_sel_a/b held at 0.
- FORWARD_EN=1:
  - hazard_detected = id_valid && EXE.mem_r_en && match_EXE on src1 or src2 (load-use).
  - fwd_sel per operand picks the youngest matching stage: EXE=1 over MEM=2 over WB=3, else 0.
  - fwd_sel is forced to 0 when hazard_detected=1, id_valid=0, or (for src2) two_src=0.
- hazard_detected and fwd_sel are purely combinational from current inputs and tags, with zero latency. flush does not gate hazard_detected.
- A load in EXE causes exactly one stall cycle in FORWARD_EN=1. The next cycle the load is in MEM, and fwd_sel=2 with no stall.
- Same dest in both EXE and MEM: EXE wins (youngest value).
- stall_cycles:
  - Increments at each edge where hazard_detected=1 && freeze=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Holds during freeze.
- id_dest equal to src1 of the same instruction is not a hazard; the instruction does not match itself.

Test Plan:
- FORWARD_EN=1: issue LDR R3, then ADD R4,R3,R5 (two_src=1) -> hazard_detected=1 for 1 cycle; next cycle hazard=0, fwd_sel_a=2; stall_cycles=1.
- FORWARD_EN=1: ADD R2, then SUB R6,R1,R2 back-to-back -> hazard=0, fwd_sel_b=1. Repeat with src2=R2 and two_src=0 -> fwd_sel_b=0.
- FORWARD_EN=0: ADD R7, then MOV R8,R7 -> hazard=1 for 2 cycles (R7 in EXE, then MEM) then 0; stall_cycles=2. With WB_HAZARD=1 -> 3 cycles.
- Freeze: hold freeze=1 for 4 cycles with a load-use pending -> tags unchanged, hazard stays 1, stall_cycles unchanged. Release -> one more stall counted, then fwd_sel_a=2.
- Flush: flush=1 with ID writing R9, then next instruction reads R9 -> EXE is a bubble, hazard=0, fwd_sel=0. Assert rst mid-stall -> next cycle hazard=0, stall_cycles=0.
- CNT_W=4: force 20 consecutive load-use stalls -> stall_cycles saturates at 15.
